// File: rtl/lcg_pkg.sv
// lcg_pkg: shared definitions for the LCG multiply/accumulate unit.
//   LCG_WIDTH   - default operand width (full product is 2*LCG_WIDTH)
//   lcg_state_e - control FSM states
//   ITER_CYCLES - cycles per a*x+c iteration (WIDTH MUL + ACC + NEXT)
package lcg_pkg;

  localparam int LCG_WIDTH   = 16;
  localparam int ITER_CYCLES = LCG_WIDTH + 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ACC  = 2'd2,
    NEXT = 2'd3
  } lcg_state_e;

endpackage

// File: rtl/lcg_shift_add_core.sv
// lcg_shift_add_core: shift-add datapath for one a*x+c iteration.
//   load     - clear accumulator, load multiplier a and multiplicand x, bit counter 0
//   step     - consume one multiplier bit (LSB first), add shifted x when set
//   acc_add  - add zero-extended addend into the accumulator
//   product  - 2*WIDTH accumulator (wraps modulo 2^(2*WIDTH))
//   bit_last - high while the final multiplier bit is being consumed
module lcg_shift_add_core
  import lcg_pkg::*;
#(
  parameter int WIDTH = LCG_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               acc_add,
  input  logic [WIDTH-1:0]   load_a,
  input  logic [WIDTH-1:0]   load_x,
  input  logic [WIDTH-1:0]   addend,
  output logic [2*WIDTH-1:0] product,
  output logic               bit_last
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [2*WIDTH-1:0] mcand;   // x << i, kept pre-shifted
  logic [WIDTH-1:0]   mplier;  // a >> i, bit 0 is the current multiplier bit
  logic [CW-1:0]      bit_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      product <= '0;
      mcand   <= '0;
      mplier  <= '0;
      bit_cnt <= '0;
    end else if (load) begin
      product <= '0;
      mcand   <= {{WIDTH{1'b0}}, load_x};
      mplier  <= load_a;
      bit_cnt <= '0;
    end else if (step) begin
      if (mplier[0]) product <= product + mcand;
      mcand   <= mcand << 1;
      mplier  <= mplier >> 1;
      bit_cnt <= bit_cnt + CW'(1);
    end else if (acc_add) begin
      product <= product + {{WIDTH{1'b0}}, addend};
    end
  end

  assign bit_last = (bit_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/lcg_mul_unit.sv
// lcg_mul_unit: multi-cycle LCG step x' = a*x + c (addend optional), optionally
// iterated count times, returning low and (optionally) high product words.
//   clk, reset        - clock, synchronous active-high reset
//   start             - request; accepted only in IDLE
//   mul_only/loop/msb - drop addend / iterate count times / return high word
//   a, x, c, count    - multiplier, seed, addend, iteration count
//   busy, stall, done - in progress / pipeline hold / one-cycle completion pulse
//   result_lo/hi      - registered results, held until the next done or reset
module lcg_mul_unit
  import lcg_pkg::*;
#(
  parameter int WIDTH = LCG_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mul_only,
  input  logic             loop,
  input  logic             msb,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi
);

  lcg_state_e state_q, state_d;

  logic [WIDTH-1:0]   a_q;     // multiplier reused by every iteration
  logic [WIDTH-1:0]   c_q;     // addend, already zeroed for mul_only
  logic [WIDTH-1:0]   rem_q;   // iterations left including the current one
  logic               msb_q;
  logic               idle, accept;
  logic               load, step, acc_add, fin;
  logic [2*WIDTH-1:0] product;
  logic               bit_last;

  assign idle   = (state_q == IDLE);
  assign accept = start & idle;
  assign busy   = ~idle;
  assign stall  = accept | busy;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    acc_add = 1'b0;
    fin     = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        load    = 1'b1;
        state_d = MUL;
      end
      MUL: begin
        step = 1'b1;
        if (bit_last) state_d = ACC;
      end
      ACC: begin
        acc_add = 1'b1;
        state_d = NEXT;
      end
      NEXT: begin
        if (rem_q > WIDTH'(1)) begin
          load    = 1'b1;
          state_d = MUL;
        end else begin
          fin     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      c_q       <= '0;
      rem_q     <= '0;
      msb_q     <= 1'b0;
      done      <= 1'b0;
      result_lo <= '0;
      result_hi <= '0;
    end else begin
      state_q <= state_d;
      done    <= fin;
      if (accept) begin
        a_q   <= a;
        c_q   <= mul_only ? '0 : c;
        msb_q <= msb;
        // count=0 behaves like a single step
        rem_q <= (loop && count != '0) ? count : WIDTH'(1);
      end else if (state_q == NEXT && rem_q > WIDTH'(1)) begin
        rem_q <= rem_q - WIDTH'(1);
      end
      if (fin) begin
        result_lo <= product[WIDTH-1:0];
        result_hi <= msb_q ? product[2*WIDTH-1:WIDTH] : '0;
      end
    end
  end

  // First load takes operands from the ports; later loads chain x from the
  // low product word and reuse the latched multiplier.
  lcg_shift_add_core #(.WIDTH(WIDTH)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .acc_add  (acc_add),
    .load_a   (idle ? a : a_q),
    .load_x   (idle ? x : product[WIDTH-1:0]),
    .addend   (c_q),
    .product  (product),
    .bit_last (bit_last)
  );

endmodule

// File: tb/tb_lcg_mul_unit.sv
module tb_lcg_mul_unit;
  import lcg_pkg::*;

  localparam int W = LCG_WIDTH;

  typedef struct {
    string        name;
    logic [W-1:0] a, x, c, count;
    logic         mul_only, loop, msb;
    logic [W-1:0] exp_lo, exp_hi;
    int           lat;
  } vec_t;

  typedef struct {
    logic [W-1:0] lo, hi;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset, start, mul_only, loop, msb;
  logic [W-1:0] a, x, c, count;
  logic         busy, stall, done;
  logic [W-1:0] result_lo, result_hi;

  int           checks = 0;
  int           errors = 0;
  exp_t         sb[$];
  logic [W-1:0] prev_lo = '0, prev_hi = '0;
  vec_t         tbl[$];

  always #5 clk = ~clk;

  lcg_mul_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .mul_only(mul_only), .loop(loop),
    .msb(msb), .a(a), .x(x), .c(c), .count(count), .busy(busy), .stall(stall),
    .done(done), .result_lo(result_lo), .result_hi(result_hi)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: iterate a*x+c in 2*W-bit arithmetic.
  function automatic vec_t model(input vec_t v);
    logic [2*W-1:0] p;
    logic [W-1:0]   xx;
    int             n;
    vec_t           r;
    r  = v;
    xx = v.x;
    p  = '0;
    n  = (v.loop && v.count != 0) ? int'(v.count) : 1;
    for (int i = 0; i < n; i++) begin
      p  = {{W{1'b0}}, v.a} * {{W{1'b0}}, xx} + {{W{1'b0}}, (v.mul_only ? {W{1'b0}} : v.c)};
      xx = p[W-1:0];
    end
    r.exp_lo = p[W-1:0];
    r.exp_hi = v.msb ? p[2*W-1:W] : '0;
    r.lat    = n * ITER_CYCLES;
    return r;
  endfunction

  // Scoreboard: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: done=1 with no outstanding request");
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result_lo", result_lo, e.lo);
        chk("result_hi", result_hi, e.hi);
      end
    end
  end

  // Issue one op; optionally re-pulse start (with a=9) at cycle poke_k while busy.
  task automatic issue(input vec_t v, input int poke_k);
    int k, bad;
    @(negedge clk);
    a = v.a; x = v.x; c = v.c; count = v.count;
    mul_only = v.mul_only; loop = v.loop; msb = v.msb; start = 1'b1;
    #1 chk({v.name, ":stall_start"}, stall, 1);
    sb.push_back('{v.exp_lo, v.exp_hi});
    @(negedge clk);
    // scramble inputs: the unit must work from values latched at accept
    start = 1'b0; a = W'($urandom); x = W'($urandom); c = W'($urandom);
    count = W'($urandom); mul_only = ~v.mul_only; loop = ~v.loop; msb = ~v.msb;
    #1;
    k = 0; bad = 0;
    while (!done && k < 2000) begin
      if (!busy || !stall || result_lo !== prev_lo || result_hi !== prev_hi) bad++;
      @(negedge clk);
      start = (k + 1 == poke_k);
      if (k + 1 == poke_k) a = W'(9);
      #1 k++;
    end
    start = 1'b0;
    chk({v.name, ":latency"}, k, v.lat);
    chk({v.name, ":busy_profile"}, bad, 0);
    chk({v.name, ":busy_at_done"}, busy, 0);
    chk({v.name, ":stall_at_done"}, stall, 0);
    prev_lo = v.exp_lo;
    prev_hi = v.exp_hi;
  endtask

  initial begin
    vec_t v;
    reset = 1'b1; start = 1'b0; mul_only = 1'b0; loop = 1'b0; msb = 1'b0;
    a = '0; x = '0; c = '0; count = '0;

    //            name         a        x        c        count mo   lp   msb  lo       hi       lat
    tbl.push_back('{"single",   16'd3,   16'd5,   16'd7,   16'd0, 1'b0,1'b0,1'b0,16'd22,  16'h0,   18});
    tbl.push_back('{"full_msb", 16'hFFFF,16'hFFFF,16'd0,   16'd0, 1'b1,1'b0,1'b1,16'h0001,16'hFFFE,18});
    tbl.push_back('{"full_lo",  16'hFFFF,16'hFFFF,16'd0,   16'd0, 1'b1,1'b0,1'b0,16'h0001,16'h0,   18});
    tbl.push_back('{"loop3",    16'd5,   16'd1,   16'd3,   16'd3, 1'b0,1'b1,1'b0,16'd218, 16'h0,   54});
    tbl.push_back('{"loop_c0",  16'd3,   16'd5,   16'd7,   16'd0, 1'b0,1'b1,1'b0,16'd22,  16'h0,   18});
    tbl.push_back('{"mul_only", 16'd3,   16'd5,   16'd7,   16'd0, 1'b1,1'b0,1'b0,16'd15,  16'h0,   18});
    tbl.push_back('{"hi_add",   16'h8000,16'd4,   16'hFFFF,16'd0, 1'b0,1'b0,1'b1,16'hFFFF,16'h0002,18});
    tbl.push_back('{"max_add",  16'hFFFF,16'hFFFF,16'hFFFF,16'd0, 1'b0,1'b0,1'b1,16'h0000,16'hFFFF,18});
    for (int i = 0; i < 4; i++) begin
      v.name = "rand"; v.a = W'($urandom); v.x = W'($urandom); v.c = W'($urandom);
      v.count = W'($urandom_range(0, 3)); v.mul_only = 1'($urandom);
      v.loop = 1'b1; v.msb = 1'b1;
      tbl.push_back(model(v));
    end

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall", stall, 0);
    chk("rst_lo", result_lo, 0);
    chk("rst_hi", result_hi, 0);
    reset = 1'b0;

    foreach (tbl[i]) issue(tbl[i], -1);

    // start while busy: second start with a=9 at cycle 5 must be ignored
    issue(tbl[0], 5);

    // reset mid-operation: no done, outputs cleared, then a clean run
    @(negedge clk);
    a = 16'd3; x = 16'd5; c = 16'd7; count = '0; mul_only = 1'b0; loop = 1'b0; msb = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_lo", result_lo, 0);
    chk("midrst_hi", result_hi, 0);
    chk("midrst_done", done, 0);
    reset = 1'b0;
    prev_lo = '0; prev_hi = '0;
    repeat (40) @(negedge clk);   // any done here is flagged by the scoreboard
    issue(tbl[0], -1);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcg_mul_unit.md
# lcg_mul_unit

Multi-cycle shift-add multiply/accumulate unit that executes the LCG instruction issued by the pipelined decoder. It computes `x' = a*x + c`, with the addend optional. It can iterate the step a programmed number of times and can return the high product word. It sits beside the ALU in the execute stage and stalls the pipeline while it runs.

## Interface
Parameters:
- `WIDTH`, 16: operand width. The full product is 2*WIDTH.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `start`, in, 1: decoder `mul_en` qualified by a valid execute slot.
- `mul_only`, in, 1: decoder `MUL`; 1 = ignore the addend (c treated as 0).
- `loop`, in, 1: decoder `loop`; 1 = iterate `count` times.
- `msb`, in, 1: decoder `MSB`; 1 = drive the high product word.
- `a`, in, WIDTH: multiplier constant (Rs).
- `x`, in, WIDTH: seed / multiplicand (Rd).
- `c`, in, WIDTH: addend (GP5).
- `count`, in, WIDTH: iteration count, used only when `loop`=1.
- `busy`, out, 1: operation in progress.
- `stall`, out, 1: hold the pipeline, combinational: `(start & idle) | busy`.
- `done`, out, 1: single-cycle completion pulse.
- `result_lo`, out, WIDTH: P[WIDTH-1:0] of the last iteration.
- `result_hi`, out, WIDTH: P[2*WIDTH-1:WIDTH] if `msb`, else 0.

## Operation
- All inputs are sampled only on the edge where `start`=1 in IDLE. `a`, `c`, `mul_only`, `msb` and the iteration total are latched there. `start` while busy is ignored.
- Iteration total N: `loop`=0 gives N=1. `loop`=1 gives N=`count`, and `count`=0 is treated as N=1.
- Per iteration: P = a*x + (mul_only ? 0 : c), modulo 2^(2*WIDTH), unsigned. The next iteration uses x = P[WIDTH-1:0].
- FSM states: IDLE, MUL, ACC, NEXT.
  - IDLE → MUL on accepted start. This loads the accumulator to 0, the multiplicand x, and bit counter 0.
  - MUL: one multiplier bit per cycle, LSB first. If a[i]=1, add x<<i into the 2*WIDTH accumulator. Runs WIDTH cycles, then goes to ACC.
  - ACC: add the zero-extended addend (or 0). Go to NEXT.
  - NEXT: if the remaining count is >1, decrement it, reload x from P[WIDTH-1:0], clear the accumulator and go to MUL. Otherwise register the results, pulse `done` and go to IDLE.
- `result_lo` and `result_hi` hold their value until the next `done` or reset. They are not disturbed during a new run.

## Timing
- Reset values: `busy`=0, `done`=0, `result_lo`=0, `result_hi`=0, state IDLE, counters 0.
- One iteration takes WIDTH+2 cycles (18 for WIDTH=16: 16 MUL, 1 ACC, 1 NEXT).
- If `start` is accepted at edge E0:
  - `busy`=1 from E0.
  - `done`=1 for exactly the cycle after edge E0 + N*(WIDTH+2).
  - `busy`=0 in that same cycle.
  - A new `start` is accepted in the `done` cycle.
- `stall` is high in the `start` cycle itself and in every busy cycle. It is low in the `done` cycle so the result can be written back.
- `reset` mid-operation: return to IDLE next edge, with all outputs zero and no `done` pulse. Partial results are discarded.
- Overflow beyond 2*WIDTH bits wraps silently. No flags are produced and the carry DFF is not touched.

## Structure
- Shared package `lcg_pkg`:
  - `WIDTH` default constant.
  - State enum {IDLE, MUL, ACC, NEXT}.
  - Localparam `ITER_CYCLES = WIDTH+2`.
- Sub-module `lcg_shift_add_core`: holds the accumulator, multiplicand shift register and bit counter. Controls are `load`, `step` and `acc_add`. Output is `bit_last`. The top level owns the FSM, the iteration counter and the result registers.

## Test plan
- Single step: a=3, x=5, c=7, mul_only=0, loop=0 → `done` at cycle 18 after start, `result_lo`=22, `result_hi`=0.
- Full-width MSB: a=0xFFFF, x=0xFFFF, mul_only=1, msb=1 → `result_lo`=0x0001, `result_hi`=0xFFFE. With msb=0 → `result_hi`=0.
- Loop: a=5, x=1, c=3, loop=1, count=3 → iterates 8, 43, 218; `result_lo`=218, `done` at cycle 54; `stall` high for cycles 0–53.
- count=0 with loop=1 → identical to a single step: a=3, x=5, c=7 gives 22 at cycle 18.
- Reset mid-op: start (a=3, x=5, c=7), assert `reset` at cycle 8 → `busy`=0, outputs 0, no `done`. A fresh start then completes normally with 22.
- Start while busy: second `start` with a=9 at cycle 5 → ignored; the result is 22 and only one `done` pulse occurs.
